// File: rtl/tone_bank_if.sv
// tone_bank_if: command port of the tone_bank multi-channel tone generator.
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  command accepted when cmd_valid && cmd_ready
//   cmd_ch     master->slave  target channel index (3 bits)
//   cmd_half   master->slave  half-period in clock cycles, 0 = stop
//   cmd_dur    master->slave  duration in ms, 0 = continuous
//   cmd_err    slave->master  one-cycle pulse on an out-of-range channel
interface tone_bank_if #(
  parameter int HALF_W = 20,
  parameter int DUR_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_ch;
  logic [HALF_W-1:0] cmd_half;
  logic [DUR_W-1:0]  cmd_dur;
  logic              cmd_err;

  modport master (output cmd_valid, cmd_ch, cmd_half, cmd_dur,
                  input  cmd_ready, cmd_err);
  modport slave  (input  cmd_valid, cmd_ch, cmd_half, cmd_dur,
                  output cmd_ready, cmd_err);
endinterface

// File: rtl/tone_bank.sv
// tone_bank: CHANNELS independent square-wave tone generators for piezo
// outputs. Each channel takes a half-period (cycles) and a duration (ms)
// through the command interface, plays, then stops and pulses done.
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   cmd       tone_bank_if.slave command port (valid/ready, ch, half, dur, err)
//   tone_out  per-channel square wave (registered)
//   busy      per-channel playing flag (registered)
//   done      per-channel one-cycle pulse on natural expiry (registered)
//   mix_out   tone of the lowest-index busy channel, one cycle late;
//             present only when the TONE_MIX_EN macro is defined
module tone_bank #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int CHANNELS = 2,
  parameter int HALF_W   = 20,
  parameter int DUR_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  tone_bank_if.slave          cmd,
  output logic [CHANNELS-1:0] tone_out,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
`ifdef TONE_MIX_EN
  ,
  output logic                mix_out
`endif
);

  localparam int MS_DIV = CLK_HZ / 1000;
  localparam int PRE_W  = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_DIV - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t              r_state      [CHANNELS];
  state_t              w_state_nxt  [CHANNELS];
  logic [HALF_W-1:0]   r_half       [CHANNELS];
  logic [HALF_W-1:0]   w_half_nxt   [CHANNELS];
  logic [HALF_W-1:0]   r_half_cnt   [CHANNELS];
  logic [HALF_W-1:0]   w_hcnt_nxt   [CHANNELS];
  logic [PRE_W-1:0]    r_pre        [CHANNELS];
  logic [PRE_W-1:0]    w_pre_nxt    [CHANNELS];
  logic [DUR_W-1:0]    r_ms_rem     [CHANNELS];
  logic [DUR_W-1:0]    w_ms_nxt     [CHANNELS];
  logic [CHANNELS-1:0] r_tone, w_tone_nxt;
  logic [CHANNELS-1:0] r_done, w_done_nxt;
  logic                r_ready;
  logic                r_err, w_err_nxt;
  logic                w_accept, w_ch_ok;
  logic [31:0]         w_ch32;

  always_comb begin
    w_ch32    = {29'd0, cmd.cmd_ch};
    w_accept  = cmd.cmd_valid && r_ready;
    w_ch_ok   = w_ch32 < 32'(CHANNELS);
    w_err_nxt = w_accept && !w_ch_ok;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      w_state_nxt[ch] = r_state[ch];
      w_half_nxt[ch]  = r_half[ch];
      w_hcnt_nxt[ch]  = r_half_cnt[ch];
      w_pre_nxt[ch]   = r_pre[ch];
      w_ms_nxt[ch]    = r_ms_rem[ch];
      w_tone_nxt[ch]  = r_tone[ch];
      w_done_nxt[ch]  = 1'b0;

      if (r_state[ch] == PLAY) begin
        if (r_half_cnt[ch] == r_half[ch] - HALF_W'(1)) begin
          w_hcnt_nxt[ch] = '0;
          w_tone_nxt[ch] = ~r_tone[ch];
        end else begin
          w_hcnt_nxt[ch] = r_half_cnt[ch] + HALF_W'(1);
        end
        // ms_rem stays 0 for continuous tones, so it never expires.
        if (r_pre[ch] == PRE_LAST) begin
          w_pre_nxt[ch] = '0;
          if (r_ms_rem[ch] == DUR_W'(1)) begin
            w_ms_nxt[ch]    = '0;
            w_state_nxt[ch] = IDLE;
            w_tone_nxt[ch]  = 1'b0;
            w_done_nxt[ch]  = 1'b1;
          end else if (r_ms_rem[ch] != '0) begin
            w_ms_nxt[ch] = r_ms_rem[ch] - DUR_W'(1);
          end
        end else begin
          w_pre_nxt[ch] = r_pre[ch] + PRE_W'(1);
        end
      end

      // A command overrides any same-edge expiry, suppressing its done.
      if (w_accept && w_ch_ok && (w_ch32 == ch)) begin
        w_done_nxt[ch] = 1'b0;
        if (cmd.cmd_half == '0) begin
          w_state_nxt[ch] = IDLE;
          w_tone_nxt[ch]  = 1'b0;
        end else begin
          w_state_nxt[ch] = PLAY;
          w_half_nxt[ch]  = cmd.cmd_half;
          w_ms_nxt[ch]    = cmd.cmd_dur;
          w_hcnt_nxt[ch]  = '0;
          w_pre_nxt[ch]   = '0;
          w_tone_nxt[ch]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        r_state[ch]    <= IDLE;
        r_half[ch]     <= '0;
        r_half_cnt[ch] <= '0;
        r_pre[ch]      <= '0;
        r_ms_rem[ch]   <= '0;
      end
      r_tone  <= '0;
      r_done  <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        r_state[ch]    <= w_state_nxt[ch];
        r_half[ch]     <= w_half_nxt[ch];
        r_half_cnt[ch] <= w_hcnt_nxt[ch];
        r_pre[ch]      <= w_pre_nxt[ch];
        r_ms_rem[ch]   <= w_ms_nxt[ch];
      end
      r_tone  <= w_tone_nxt;
      r_done  <= w_done_nxt;
      r_ready <= 1'b1;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      busy[ch] = (r_state[ch] == PLAY);
    end
  end

  assign tone_out      = r_tone;
  assign done          = r_done;
  assign cmd.cmd_ready = r_ready;
  assign cmd.cmd_err   = r_err;

`ifdef TONE_MIX_EN
  logic r_mix, w_mix_nxt, w_found;

  always_comb begin
    w_mix_nxt = 1'b0;
    w_found   = 1'b0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      if (!w_found && (r_state[ch] == PLAY)) begin
        w_mix_nxt = r_tone[ch];
        w_found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mix <= 1'b0;
    else        r_mix <= w_mix_nxt;
  end

  assign mix_out = r_mix;
`endif

endmodule

// File: tb/tb_tone_bank.sv
// tb_tone_bank: self-checking bench for tone_bank (CLK_HZ = 10_000, so
// 1 ms = 10 cycles; CHANNELS = 2). Every cycle is compared against a
// reference model that derives each channel's outputs from the time
// elapsed since its last accepted command.
module tb_tone_bank;
  localparam int CH = 2;
  localparam int HW = 20;
  localparam int DW = 16;
  localparam int MS = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] tone_out, busy, done;
`ifdef TONE_MIX_EN
  logic          mix_out;
`endif

  tone_bank_if #(.HALF_W(HW), .DUR_W(DW)) bus ();

  tone_bank #(.CLK_HZ(10_000), .CHANNELS(CH), .HALF_W(HW), .DUR_W(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd(bus),
    .tone_out(tone_out),
    .busy(busy),
    .done(done)
`ifdef TONE_MIX_EN
    ,
    .mix_out(mix_out)
`endif
  );

  always #5 clk = ~clk;

  int   n_err = 0;
  int   n_chk = 0;
  int   cyc = 0;
  bit   m_ready;
  bit   m_act   [CH];
  int   m_start [CH];
  int   m_half  [CH];
  int   m_dur   [CH];
  logic m_mix_src;
  int   c_busy, c_done, c_err, c_high;

  typedef struct {
    int ch; int half; int dur; int win;
    int busy_n; int done_n; int high_n; int err_n;
  } vec_t;
  vec_t vt[5];

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  task automatic model_reset();
    m_ready = 1'b0;
    for (int c = 0; c < CH; c++) m_act[c] = 1'b0;
    m_mix_src = 1'b0;
  endtask

  // One clock edge: update the model with the command present at the edge,
  // then compare every registered output #1 after the edge.
  task automatic step(input string name);
    logic [CH-1:0] et, eb, ed;
    logic          ee;
    int            ch, e;
    @(posedge clk);
    #1;
    cyc++;
    ee = 1'b0;
    ch = int'(bus.cmd_ch);
    if (m_ready && bus.cmd_valid) begin
      if (ch >= CH) ee = 1'b1;
      else if (bus.cmd_half == '0) m_act[ch] = 1'b0;
      else begin
        m_act[ch]   = 1'b1;
        m_start[ch] = cyc;
        m_half[ch]  = int'(bus.cmd_half);
        m_dur[ch]   = int'(bus.cmd_dur);
      end
    end
    m_ready = 1'b1;
    et = '0; eb = '0; ed = '0;
    for (int c = 0; c < CH; c++) begin
      if (m_act[c]) begin
        e = cyc - m_start[c];
        if (m_dur[c] != 0 && e >= m_dur[c] * MS) begin
          ed[c] = (e == m_dur[c] * MS);
        end else begin
          eb[c] = 1'b1;
          et[c] = ((e / m_half[c]) % 2 == 0);
        end
      end
    end
    check(name, {24'd0, bus.cmd_ready, bus.cmd_err, done, busy, tone_out},
                {24'd0, 1'b1, ee, ed, eb, et});
`ifdef TONE_MIX_EN
    check({name, "/mix"}, {31'd0, mix_out}, {31'd0, m_mix_src});
    m_mix_src = 1'b0;
    for (int c = CH - 1; c >= 0; c--) if (eb[c]) m_mix_src = et[c];
`endif
    c_busy += $countones(busy);
    c_done += $countones(done);
    c_err  += int'(bus.cmd_err);
    c_high += $countones(tone_out);
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) step(name);
  endtask

  task automatic send(input int ch, input int half, input int dur, input string name);
    bus.cmd_valid = 1'b1;
    bus.cmd_ch    = 3'(ch);
    bus.cmd_half  = HW'(half);
    bus.cmd_dur   = DW'(dur);
    step(name);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic stop_all();
    send(0, 0, 0, "stop0");
    send(1, 0, 0, "stop1");
  endtask

  task automatic clear_counts();
    c_busy = 0; c_done = 0; c_err = 0; c_high = 0;
  endtask

  initial begin
    //        ch half dur win busy done high err
    vt[0] = '{0, 4, 3, 40, 30, 1, 16, 0};
    vt[1] = '{1, 2, 0, 40, 40, 0, 20, 0};
    vt[2] = '{0, 1, 1, 20, 10, 1,  5, 0};
    vt[3] = '{1, 3, 2, 25, 20, 1, 11, 0};
    vt[4] = '{2, 4, 3, 10,  0, 0,  0, 1};

    bus.cmd_valid = 1'b0;
    bus.cmd_ch    = '0;
    bus.cmd_half  = '0;
    bus.cmd_dur   = '0;
    model_reset();
    clear_counts();

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {24'd0, bus.cmd_ready, bus.cmd_err, done, busy, tone_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset");

    // Table-driven single-command windows
    for (int i = 0; i < 5; i++) begin
      clear_counts();
      send(vt[i].ch, vt[i].half, vt[i].dur, "vec_cmd");
      idle(vt[i].win - 1, "vec_run");
      check("vec_busy_cycles", 32'(c_busy), 32'(vt[i].busy_n));
      check("vec_done_pulses", 32'(c_done), 32'(vt[i].done_n));
      check("vec_high_cycles", 32'(c_high), 32'(vt[i].high_n));
      check("vec_err_pulses",  32'(c_err),  32'(vt[i].err_n));
      stop_all();
    end

    // Continuous play then stop
    clear_counts();
    send(1, 2, 0, "cont_cmd");
    idle(499, "cont_run");
    check("cont_busy_cycles", 32'(c_busy), 32'd500);
    send(1, 0, 0, "cont_stop");
    check("cont_stop_outputs", {26'd0, done, busy, tone_out}, 32'd0);
    clear_counts();
    idle(5, "cont_after");
    check("cont_no_done", 32'(c_done), 32'd0);

    // Retrigger at k+12
    clear_counts();
    send(0, 4, 3, "retrig_a");
    idle(11, "retrig_wait");
    c_busy = 0;
    send(0, 2, 1, "retrig_b");
    check("retrig_tone_high", {31'd0, tone_out[0]}, 32'd1);
    idle(20, "retrig_run");
    check("retrig_busy_cycles", 32'(c_busy), 32'd10);
    check("retrig_done_pulses", 32'(c_done), 32'd1);

    // Command on the natural-expiry edge wins
    send(0, 2, 1, "coll_a");
    idle(9, "coll_wait");
    send(0, 3, 1, "coll_b");
    check("coll_no_done", {30'd0, done[0], busy[0]}, 32'd1);
    stop_all();

    // Mixed channels plus invalid channel
    send(0, 3, 0, "mix_ch0");
    send(1, 5, 0, "mix_ch1");
    idle(60, "mix_run");
    clear_counts();
    send(2, 7, 2, "bad_ch");
    idle(3, "bad_after");
    check("bad_err_pulses", 32'(c_err), 32'd1);
    check("bad_busy_kept", {30'd0, busy}, 32'd3);

`ifdef TONE_MIX_EN
    idle(30, "mixout_both");
    send(0, 0, 0, "mixout_stop0");
    idle(30, "mixout_ch1");
`endif

    // Asynchronous reset mid-cycle while both channels play
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", {24'd0, bus.cmd_ready, bus.cmd_err, done, busy, tone_out}, 32'd0);
`ifdef TONE_MIX_EN
    check("async_reset_mix", {31'd0, mix_out}, 32'd0);
`endif
    model_reset();
    #10;
    @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    step("rst_release");
    idle(5, "rst_after");
    check("rst_no_done", 32'(c_done), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0)
        send(int'($urandom_range(0, 2)), int'($urandom_range(0, 5)),
             int'($urandom_range(0, 3)), "rand_cmd");
      else
        step("rand_idle");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
